// File: rtl/pbc_pkg.sv
// Shared constants for the parity bit checker: parity sense encodings,
// synchronizer depth and the default error-counter width.
package pbc_pkg;

  localparam bit          PAR_EVEN    = 1'b0;
  localparam bit          PAR_ODD     = 1'b1;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DEF_CNT_W   = 8;

endpackage : pbc_pkg

// File: rtl/pbc_sync2.sv
// Multi-flop reset-to-zero synchronizer, SYNC_STAGES deep, W independent bits wide.
module pbc_sync2
  import pbc_pkg::*;
#(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [SYNC_STAGES-1:0][W-1:0] stg_q;
  logic [SYNC_STAGES-1:0][W-1:0] stg_d;

  // Stage 0 captures the asynchronous input; later stages shift it along.
  always_comb begin
    stg_d = {stg_q[SYNC_STAGES-2:0], din};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_q <= '0;
    end else begin
      stg_q <= stg_d;
    end
  end

  assign dout = stg_q[SYNC_STAGES-1];

endmodule : pbc_sync2

// File: rtl/parity_bit_checker.sv
// Synchronizes a 4-bit nibble plus parity bit and registers a parity-error flag.
// Define PBC_ERR_STATS_EN to add the sticky error flag and saturating error counter.
module parity_bit_checker
  import pbc_pkg::*;
#(
  parameter bit          ODD_PAR = PAR_EVEN,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             p,
  output logic             e
`ifdef PBC_ERR_STATS_EN
  ,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  localparam int unsigned IN_W = 5;

  logic [IN_W-1:0] raw_c;
  logic [IN_W-1:0] syn_c;
  logic            err_c;
  logic            e_q;
  logic            e_d;

  assign raw_c = {p, d, c, b, a};

  pbc_sync2 #(
    .W (IN_W)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (raw_c),
    .dout  (syn_c)
  );

  // Even sense flags an odd sum; odd sense flags an even sum.
  assign err_c = (ODD_PAR == PAR_ODD) ? ~(^syn_c) : (^syn_c);

`ifdef PBC_ERR_STATS_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sticky_q;
  logic             sticky_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A new error event is the cycle e is about to rise; the counter saturates.
  always_comb begin
    e_d      = err_c;
    sticky_d = sticky_q | err_c;
    cnt_d    = cnt_q;
    if (err_c && !e_q && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q      <= 1'b0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      e_q      <= e_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign err_sticky = sticky_q;
  assign err_cnt    = cnt_q;
`else
  // CNT_W only sizes the stats counter; keep it referenced in this build.
  if (CNT_W == 0) begin : g_cnt_w_unused
  end

  always_comb begin
    e_d = err_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q <= 1'b0;
    end else begin
      e_q <= e_d;
    end
  end
`endif

  assign e = e_q;

endmodule : parity_bit_checker

// File: tb/tb_parity_bit_checker.sv
// Directed bench for parity_bit_checker: even and odd instances share inputs.
module tb_parity_bit_checker;

  logic       clk;
  logic       rst_n;
  logic       a, b, c, d, p;
  logic       e_even, e_odd;
`ifdef PBC_ERR_STATS_EN
  logic       sticky_even, sticky_odd;
  logic [1:0] cnt_even;
  logic [7:0] cnt_odd;
`endif

  int total = 0;
  int bad   = 0;

  // Reference pipeline: raw parity sum delayed through two stages, then registered.
  logic m1, m2, exp_even, exp_odd;

  parity_bit_checker #(.ODD_PAR(1'b0), .CNT_W(2)) dut_even (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .p(p), .e(e_even)
`ifdef PBC_ERR_STATS_EN
    , .err_sticky(sticky_even), .err_cnt(cnt_even)
`endif
  );

  parity_bit_checker #(.ODD_PAR(1'b1), .CNT_W(8)) dut_odd (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .d(d), .p(p), .e(e_odd)
`ifdef PBC_ERR_STATS_EN
    , .err_sticky(sticky_odd), .err_cnt(cnt_odd)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m1 <= 1'b0; m2 <= 1'b0; exp_even <= 1'b0; exp_odd <= 1'b0;
    end else begin
      m1       <= a ^ b ^ c ^ d ^ p;
      m2       <= m1;
      exp_even <= m2;
      exp_odd  <= ~m2;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [4:0] v);
    {p, d, c, b, a} = v;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_in(5'b00000);
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_in(5'(i * 7 + 3));
      step();
      total += 2;
      if (e_even !== 1'b0) begin bad++; $display("FAIL reset_e_even cyc%0d: got %b want 0", i, e_even); end
      if (e_odd !== 1'b0) begin bad++; $display("FAIL reset_e_odd cyc%0d: got %b want 0", i, e_odd); end
`ifdef PBC_ERR_STATS_EN
      total += 2;
      if (sticky_even !== 1'b0 || sticky_odd !== 1'b0) begin
        bad++; $display("FAIL reset_sticky cyc%0d: got %b/%b want 0/0", i, sticky_even, sticky_odd);
      end
      if (cnt_even !== 2'd0 || cnt_odd !== 8'd0) begin
        bad++; $display("FAIL reset_cnt cyc%0d: got %0d/%0d want 0/0", i, cnt_even, cnt_odd);
      end
`endif
    end
    rst_n = 1'b1;
  endtask

  task automatic test_even_parity();
    logic exp_seq [3] = '{1'b0, 1'b0, 1'b1};
    set_in(5'b01010);  // a=0 b=1 c=0 d=1 p=0
    repeat (4) step();
    total++;
    if (e_even !== 1'b0) begin bad++; $display("FAIL even_ok: got %b want 0", e_even); end
    p = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (e_even !== exp_seq[i]) begin
        bad++; $display("FAIL even_lat edge%0d: got %b want %b", i + 1, e_even, exp_seq[i]);
      end
    end
  endtask

  task automatic test_odd_parity();
    logic exp_err [3] = '{1'b0, 1'b0, 1'b1};
    logic exp_ok  [3] = '{1'b1, 1'b1, 1'b0};
    set_in(5'b01111);  // a=b=c=d=1 p=0
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (e_odd !== exp_err[i]) begin
        bad++; $display("FAIL odd_err edge%0d: got %b want %b", i + 1, e_odd, exp_err[i]);
      end
    end
    p = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (e_odd !== exp_ok[i]) begin
        bad++; $display("FAIL odd_ok edge%0d: got %b want %b", i + 1, e_odd, exp_ok[i]);
      end
    end
  endtask

  task automatic test_stats();
`ifdef PBC_ERR_STATS_EN
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    apply_reset();
    for (int k = 0; k < 5; k++) begin
      set_in(5'b10000);
      repeat (4) step();
      set_in(5'b00000);
      repeat (4) step();
      total += 3;
      if (e_even !== 1'b0) begin bad++; $display("FAIL stats_e pulse%0d: got %b want 0", k + 1, e_even); end
      if (cnt_even !== exp_cnt[k]) begin
        bad++; $display("FAIL stats_cnt pulse%0d: got %0d want %0d", k + 1, cnt_even, exp_cnt[k]);
      end
      if (sticky_even !== 1'b1) begin
        bad++; $display("FAIL stats_sticky pulse%0d: got %b want 1", k + 1, sticky_even);
      end
    end
`endif
  endtask

  task automatic test_mid_reset();
    logic exp_ev [3] = '{1'b0, 1'b0, 1'b1};
    logic exp_od [3] = '{1'b1, 1'b1, 1'b0};
    apply_reset();
    set_in(5'b10000);
    repeat (4) step();
    set_in(5'b00000);
    repeat (4) step();
    set_in(5'b10000);
    repeat (4) step();
    total++;
    if (e_even !== 1'b1) begin bad++; $display("FAIL mid_pre_e: got %b want 1", e_even); end
`ifdef PBC_ERR_STATS_EN
    total++;
    if (cnt_even !== 2'd2) begin bad++; $display("FAIL mid_pre_cnt: got %0d want 2", cnt_even); end
`endif
    #2;
    rst_n = 1'b0;
    #1;
    total += 2;
    if (e_even !== 1'b0) begin bad++; $display("FAIL mid_rst_e_even: got %b want 0", e_even); end
    if (e_odd !== 1'b0) begin bad++; $display("FAIL mid_rst_e_odd: got %b want 0", e_odd); end
`ifdef PBC_ERR_STATS_EN
    total++;
    if (cnt_even !== 2'd0 || sticky_even !== 1'b0) begin
      bad++; $display("FAIL mid_rst_stats: got cnt=%0d sticky=%b want 0/0", cnt_even, sticky_even);
    end
`endif
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total += 2;
      if (e_even !== exp_ev[i]) begin
        bad++; $display("FAIL mid_rel_even edge%0d: got %b want %b", i + 1, e_even, exp_ev[i]);
      end
      if (e_odd !== exp_od[i]) begin
        bad++; $display("FAIL mid_rel_odd edge%0d: got %b want %b", i + 1, e_odd, exp_od[i]);
      end
    end
  endtask

  task automatic test_free_run();
    int elapsed = 0;
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      elapsed += 10;
      if (elapsed % 20 == 0)  a = ~a;
      if (elapsed % 30 == 0)  b = ~b;
      if (elapsed % 50 == 0)  c = ~c;
      if (elapsed % 70 == 0)  d = ~d;
      if (elapsed % 110 == 0) p = ~p;
      step();
      total += 2;
      if (e_even !== exp_even) begin
        bad++; $display("FAIL free_even t=%0d: got %b want %b", elapsed, e_even, exp_even);
      end
      if (e_odd !== exp_odd) begin
        bad++; $display("FAIL free_odd t=%0d: got %b want %b", elapsed, e_odd, exp_odd);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(5'b00000);
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_stats();
    test_mid_reset();
    test_free_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_parity_bit_checker
